// File: rtl/tx_burst_sequencer.sv
// Periodic burst transmit-request generator driving the UART TX_En_Sig/TX_Done_Sig handshake.
// Optional macro TX_BURST_CRLF_EN appends a CR/LF pair after every burst.
module tx_burst_sequencer #(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 25,
  parameter int                PERIOD    = 5_999_999,
  parameter int                MSG_LEN   = 4,
  parameter logic [DATA_W-1:0] START_VAL = 8'h32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Run,
  input  logic              Mode,
  input  logic              TX_Done_Sig,
  output logic              TX_En_Sig,
  output logic [DATA_W-1:0] TX_Data,
  output logic              Busy,
  output logic              Burst_Done,
  output logic              Overrun
);

  localparam int IDX_W = 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

`ifdef TX_BURST_CRLF_EN
  typedef enum logic [2:0] {IDLE, SEND, GAP, CR, LF} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               pend_q, pend_d;
  logic               done_d, ovr_d;
  logic               tick;

  assign tick = Run && (cnt_q == CNT_W'(PERIOD));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q      <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= START_VAL;
      pend_q     <= 1'b0;
      Burst_Done <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      if (!Run || cnt_q == CNT_W'(PERIOD))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      Burst_Done <= done_d;
      Overrun    <= ovr_d;
    end
  end

  // Under CRLF the byte index keeps counting past the data bytes so GAP knows what follows it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    ovr_d   = tick && pend_q;
    if (tick && state_q != IDLE)
      pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = SEND;
          idx_d   = '0;
          pend_d  = 1'b0;
          if (Mode)
            data_d = START_VAL;
        end
      end
      SEND: begin
        if (TX_Done_Sig) begin
          data_d = data_q + 1'b1;
`ifdef TX_BURST_CRLF_EN
          idx_d   = idx_q + 1'b1;
          state_d = GAP;
`else
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = GAP;
          end
`endif
        end
      end
      GAP: begin
`ifdef TX_BURST_CRLF_EN
        if (idx_q < IDX_W'(MSG_LEN))
          state_d = SEND;
        else if (idx_q == IDX_W'(MSG_LEN))
          state_d = CR;
        else
          state_d = LF;
`else
        state_d = SEND;
`endif
      end
`ifdef TX_BURST_CRLF_EN
      CR: begin
        if (TX_Done_Sig) begin
          idx_d   = idx_q + 1'b1;
          state_d = GAP;
        end
      end
      LF: begin
        if (TX_Done_Sig) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TX_Data = data_q;
`ifdef TX_BURST_CRLF_EN
    if (state_q == CR)
      TX_Data = DATA_W'(8'h0D);
    else if (state_q == LF)
      TX_Data = DATA_W'(8'h0A);
`endif
  end

`ifdef TX_BURST_CRLF_EN
  assign TX_En_Sig = (state_q == SEND) || (state_q == CR) || (state_q == LF);
`else
  assign TX_En_Sig = (state_q == SEND);
`endif
  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Randomized self-checking bench for tx_burst_sequencer with a transaction-level reference model.
module tb_tx_burst_sequencer;

  localparam int         DATA_W    = 8;
  localparam int         CNT_W     = 25;
  localparam int         PERIOD    = 9;
  localparam int         MSG_LEN   = 3;
  localparam logic [7:0] START_VAL = 8'hFE;
`ifdef TX_BURST_CRLF_EN
  localparam int BURST_BYTES = MSG_LEN + 2;
`else
  localparam int BURST_BYTES = MSG_LEN;
`endif

  logic              CLK = 1'b0;
  logic              RSTn, Run, Mode, TX_Done_Sig;
  logic              TX_En_Sig, Busy, Burst_Done, Overrun;
  logic [DATA_W-1:0] TX_Data;

  int tests  = 0;
  int failed = 0;

  // TX responder configuration
  int lat_min  = 4;
  int lat_max  = 4;
  bit spurious = 1'b0;

  // Monitor / reference model state
  int   cyc, phase, first_en, exp_ovr, ovr_cnt, bd_cnt, bd_bad, gap_bad, gap_run;
  int   burst_pos, last_bd_cyc, restart_gap;
  bit   pend_m, prev_busy, prev_done, idle_mode;
  logic [7:0] ref_data;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  tx_burst_sequencer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .PERIOD(PERIOD), .MSG_LEN(MSG_LEN), .START_VAL(START_VAL)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Run(Run), .Mode(Mode), .TX_Done_Sig(TX_Done_Sig),
    .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data), .Busy(Busy), .Burst_Done(Burst_Done),
    .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // UART TX stand-in: answers each request with a Done pulse after a random latency.
  initial begin : tx_model
    int en_cycles;
    int cur_lat;
    en_cycles   = 0;
    cur_lat     = 4;
    TX_Done_Sig = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (TX_Done_Sig) begin
        TX_Done_Sig = 1'b0;
        en_cycles   = 0;
      end else if (TX_En_Sig === 1'b1) begin
        en_cycles++;
        if (en_cycles == 1)
          cur_lat = $urandom_range(lat_max, lat_min);
        if (en_cycles >= cur_lat)
          TX_Done_Sig = 1'b1;
      end else begin
        en_cycles = 0;
        if (spurious && $urandom_range(3, 0) == 0)
          TX_Done_Sig = 1'b1;
      end
    end
  end

  // Observes the bus once per cycle and builds expected bytes and overrun counts from the rules.
  always @(negedge CLK) begin
    bit tick_m;
    if (RSTn !== 1'b1) begin
      cyc = 0; phase = 0; first_en = -1; exp_ovr = 0; ovr_cnt = 0; bd_cnt = 0;
      bd_bad = 0; gap_bad = 0; gap_run = 0; burst_pos = 0; last_bd_cyc = -1;
      restart_gap = -1; pend_m = 0; prev_busy = 0; prev_done = 0; idle_mode = Mode;
      ref_data = START_VAL;
      obs_q.delete();
      exp_q.delete();
    end else begin
      tick_m = Run && (phase == PERIOD);
      if (Busy === 1'b1 && !prev_busy) begin
        pend_m = 0;
        if (idle_mode)
          ref_data = START_VAL;
        for (int i = 0; i < MSG_LEN; i++) begin
          exp_q.push_back(ref_data);
          ref_data = ref_data + 8'd1;
        end
`ifdef TX_BURST_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
        burst_pos = 0;
        if (first_en < 0)
          first_en = cyc;
        if (last_bd_cyc >= 0)
          restart_gap = cyc - last_bd_cyc;
      end
      if (tick_m) begin
        if (pend_m)
          exp_ovr++;
        else if (Busy === 1'b1)
          pend_m = 1;
      end
      if (Burst_Done === 1'b1) begin
        bd_cnt++;
        last_bd_cyc = cyc;
        if (!(prev_done && burst_pos == BURST_BYTES))
          bd_bad++;
      end
      if (Overrun === 1'b1)
        ovr_cnt++;
      if (prev_done && TX_En_Sig === 1'b1)
        gap_bad++;
      if (Busy === 1'b1 && TX_En_Sig === 1'b0) begin
        gap_run++;
      end else begin
        if (TX_En_Sig === 1'b1 && gap_run > 1)
          gap_bad++;
        gap_run = 0;
      end
      prev_done = (TX_En_Sig === 1'b1) && (TX_Done_Sig === 1'b1);
      if (prev_done) begin
        obs_q.push_back(TX_Data);
        burst_pos++;
      end
      if (Busy !== 1'b1)
        idle_mode = Mode;
      prev_busy = (Busy === 1'b1);
      phase = !Run ? 0 : (phase == PERIOD ? 0 : phase + 1);
      cyc++;
    end
  end

  task automatic apply_reset(input bit mode_val);
    RSTn = 1'b0;
    Run  = 1'b1;
    Mode = mode_val;
    repeat (3) @(posedge CLK);
    #2;
    RSTn = 1'b1;
  endtask

  task automatic wait_bursts(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (bd_cnt < n && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
    end
    ok = (bd_cnt >= n);
  endtask

  task automatic drain(input int budget, output bit ok);
    int quiet;
    int k;
    quiet = 0;
    k     = 0;
    @(posedge CLK);
    #2;
    Run = 1'b0;
    while (quiet < 4 && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
      if (Busy === 1'b0) quiet++;
      else quiet = 0;
    end
    ok = (quiet >= 4);
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    Run  = 1'b1;
    Mode = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (TX_En_Sig !== 1'b0) begin failed++; $display("[TB] FAIL reset_en got %b want 0", TX_En_Sig); end
    tests++; if (Busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    tests++; if (TX_Data !== START_VAL) begin failed++; $display("[TB] FAIL reset_data got %h want %h", TX_Data, START_VAL); end
    tests++; if (Burst_Done !== 1'b0) begin failed++; $display("[TB] FAIL reset_burst_done got %b want 0", Burst_Done); end
    tests++; if (Overrun !== 1'b0) begin failed++; $display("[TB] FAIL reset_overrun got %b want 0", Overrun); end
  endtask

  task automatic test_continue_mode;
    bit ok;
    lat_min = 4; lat_max = 4; spurious = 1'b0;
    apply_reset(1'b0);
    wait_bursts(3, 400, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL cont_timeout bursts %0d want 3", bd_cnt); end
    tests++; if (first_en != PERIOD + 1) begin failed++; $display("[TB] FAIL cont_first_en cycle %0d want %0d", first_en, PERIOD + 1); end
    tests++; if (obs_q.size() < 3 * BURST_BYTES) begin failed++; $display("[TB] FAIL cont_count got %0d want %0d", obs_q.size(), 3 * BURST_BYTES); end
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL cont_byte[%0d] got %h want %h", i, obs_q[i], (i < exp_q.size()) ? exp_q[i] : 8'hxx);
      end
    end
    if (obs_q.size() > BURST_BYTES) begin
      tests++; if (obs_q[2] !== 8'h00) begin failed++; $display("[TB] FAIL cont_wrap got %h want 00", obs_q[2]); end
      tests++; if (obs_q[BURST_BYTES] !== 8'h01) begin failed++; $display("[TB] FAIL cont_next_start got %h want 01", obs_q[BURST_BYTES]); end
    end
    tests++; if (bd_cnt != obs_q.size() / BURST_BYTES) begin failed++; $display("[TB] FAIL cont_burst_done got %0d want %0d", bd_cnt, obs_q.size() / BURST_BYTES); end
    tests++; if (bd_bad != 0) begin failed++; $display("[TB] FAIL cont_bd_timing got %0d stray want 0", bd_bad); end
    tests++; if (gap_bad != 0) begin failed++; $display("[TB] FAIL cont_gap got %0d bad gaps want 0", gap_bad); end
    tests++; if (ovr_cnt != exp_ovr) begin failed++; $display("[TB] FAIL cont_overrun got %0d want %0d", ovr_cnt, exp_ovr); end
  endtask

  task automatic test_restart_mode;
    bit ok;
    lat_min = 4; lat_max = 4; spurious = 1'b0;
    apply_reset(1'b1);
    wait_bursts(3, 400, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL restart_timeout bursts %0d want 3", bd_cnt); end
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL restart_byte[%0d] got %h want %h", i, obs_q[i], (i < exp_q.size()) ? exp_q[i] : 8'hxx);
      end
    end
    if (obs_q.size() > 2 * BURST_BYTES) begin
      tests++; if (obs_q[BURST_BYTES] !== START_VAL) begin failed++; $display("[TB] FAIL restart_second_start got %h want %h", obs_q[BURST_BYTES], START_VAL); end
      tests++; if (obs_q[2 * BURST_BYTES + 1] !== 8'hFF) begin failed++; $display("[TB] FAIL restart_third_b1 got %h want ff", obs_q[2 * BURST_BYTES + 1]); end
    end
  endtask

  task automatic test_overrun;
    bit ok;
    lat_min = 25; lat_max = 25; spurious = 1'b0;
    apply_reset(1'b0);
    wait_bursts(2, 600, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL ovr_timeout bursts %0d want 2", bd_cnt); end
    tests++; if (restart_gap != 1) begin failed++; $display("[TB] FAIL ovr_restart_gap got %0d want 1", restart_gap); end
    drain(600, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL ovr_drain busy %b want 0", Busy); end
    tests++; if (ovr_cnt == 0) begin failed++; $display("[TB] FAIL ovr_seen got %0d pulses want >0", ovr_cnt); end
    tests++; if (ovr_cnt != exp_ovr) begin failed++; $display("[TB] FAIL ovr_count got %0d want %0d", ovr_cnt, exp_ovr); end
    tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("[TB] FAIL ovr_bytes got %0d want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (bd_bad != 0) begin failed++; $display("[TB] FAIL ovr_bd_timing got %0d stray want 0", bd_bad); end
  endtask

  task automatic test_random;
    bit ok;
    lat_min = 1; lat_max = 6; spurious = 1'b1;
    apply_reset(1'b0);
    repeat (800) begin
      @(posedge CLK);
      #2;
      Mode = 1'($urandom_range(1, 0));
      if ($urandom_range(24, 0) == 0)
        Run = ~Run;
    end
    drain(800, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL rand_drain busy %b want 0", Busy); end
    tests++; if (obs_q.size() != exp_q.size()) begin failed++; $display("[TB] FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL rand_byte[%0d] got %h want %h", i, obs_q[i], (i < exp_q.size()) ? exp_q[i] : 8'hxx);
      end
    end
    tests++; if (bd_cnt != obs_q.size() / BURST_BYTES) begin failed++; $display("[TB] FAIL rand_burst_done got %0d want %0d", bd_cnt, obs_q.size() / BURST_BYTES); end
    tests++; if (bd_bad != 0) begin failed++; $display("[TB] FAIL rand_bd_timing got %0d stray want 0", bd_bad); end
    tests++; if (gap_bad != 0) begin failed++; $display("[TB] FAIL rand_gap got %0d bad gaps want 0", gap_bad); end
    tests++; if (ovr_cnt != exp_ovr) begin failed++; $display("[TB] FAIL rand_overrun got %0d want %0d", ovr_cnt, exp_ovr); end
    spurious = 1'b0;
  endtask

  task automatic test_reset_midburst;
    bit ok;
    int k;
    lat_min = 4; lat_max = 4; spurious = 1'b0;
    apply_reset(1'b0);
    k = 0;
    while (!(burst_pos == 1 && TX_En_Sig === 1'b1) && k < 200) begin
      @(negedge CLK);
      #1;
      k++;
    end
    tests++; if (!(burst_pos == 1 && TX_En_Sig === 1'b1)) begin failed++; $display("[TB] FAIL mid_reach got pos %0d en %b want 1/1", burst_pos, TX_En_Sig); end
    RSTn = 1'b0;
    #1;
    tests++; if (TX_En_Sig !== 1'b0) begin failed++; $display("[TB] FAIL mid_en got %b want 0", TX_En_Sig); end
    tests++; if (Busy !== 1'b0) begin failed++; $display("[TB] FAIL mid_busy got %b want 0", Busy); end
    tests++; if (TX_Data !== START_VAL) begin failed++; $display("[TB] FAIL mid_data got %h want %h", TX_Data, START_VAL); end
    repeat (2) @(posedge CLK);
    #2;
    RSTn = 1'b1;
    wait_bursts(1, 200, ok);
    tests++; if (!ok) begin failed++; $display("[TB] FAIL mid_timeout bursts %0d want 1", bd_cnt); end
    tests++; if (first_en != PERIOD + 1) begin failed++; $display("[TB] FAIL mid_first_en cycle %0d want %0d", first_en, PERIOD + 1); end
    tests++; if (obs_q.size() < 1 || obs_q[0] !== START_VAL) begin failed++; $display("[TB] FAIL mid_first_byte got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 8'hxx, START_VAL); end
  endtask

  initial begin
    RSTn = 1'b0;
    Run  = 1'b0;
    Mode = 1'b0;
    test_reset();
    test_continue_mode();
    test_restart_mode();
    test_overrun();
    test_random();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
